// File: rtl/even_parity_tx.sv
// even_parity_tx: accepts a DATA_W-bit payload and sends it as a serial
// frame. The frame is DATA_W data bits followed by one even-parity bit.
// A new payload can be accepted in the parity cycle, so frames can run
// back to back with no gap cycle.
module even_parity_tx #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic              dout,
  output logic              dout_vld,
  output logic              dout_par,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              dout_par_q, dout_par_d;
  logic              busy_q, busy_d;
  logic              din_rdy_s;
  logic              accept_s;

  // XOR of every payload bit; a frame whose parity bit equals this has
  // an even total number of ones.
  function automatic logic parity_f(input logic [DATA_W-1:0] v);
    parity_f = ^v;
  endfunction

  // The bit that goes out first from the value v.
  function automatic logic first_bit_f(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) begin
      first_bit_f = v[DATA_W-1];
    end else begin
      first_bit_f = v[0];
    end
  endfunction

  // Drops the bit that was just sent, so the next bit moves to the output end.
  function automatic logic [DATA_W-1:0] shift_f(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) begin
      shift_f = {v[DATA_W-2:0], 1'b0};
    end else begin
      shift_f = {1'b0, v[DATA_W-1:1]};
    end
  endfunction

  assign accept_s = din_vld && din_rdy_s;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An unencoded state goes back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_PARITY;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (accept_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values. The shift register holds the bits
  // still to be sent after the one currently on dout.
  always_comb begin
    din_rdy_s  = 1'b0;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    dout_d     = 1'b0;
    dout_vld_d = 1'b0;
    dout_par_d = 1'b0;
    case (state_q)
      ST_IDLE:   din_rdy_s = 1'b1;
      ST_PARITY: din_rdy_s = 1'b1;
      default:   din_rdy_s = 1'b0;
    endcase
    if (accept_s) begin
      shreg_d    = shift_f(din);
      par_d      = parity_f(din);
      cnt_d      = {CNT_W{1'b0}};
      dout_d     = first_bit_f(din);
      dout_vld_d = 1'b1;
    end else if (state_q == ST_DATA) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d      = {CNT_W{1'b0}};
        dout_d     = par_q;
        dout_vld_d = 1'b1;
        dout_par_d = 1'b1;
      end else begin
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        shreg_d    = shift_f(shreg_q);
        dout_d     = first_bit_f(shreg_q);
        dout_vld_d = 1'b1;
      end
    end else begin
      dout_d     = 1'b0;
      dout_vld_d = 1'b0;
    end
    busy_d = (state_d == ST_DATA) || (state_d == ST_PARITY);
  end

  // Datapath and output registers. Reset clears them, which also aborts a
  // frame that is in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= {CNT_W{1'b0}};
      shreg_q    <= {DATA_W{1'b0}};
      par_q      <= 1'b0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_par_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_par_q <= dout_par_d;
      busy_q     <= busy_d;
    end
  end

  assign din_rdy  = din_rdy_s;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_par = dout_par_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_even_parity_tx.sv
// Directed testbench for even_parity_tx. It uses one LSB-first instance
// and one MSB-first instance, and both share the same stimulus.
module tb_even_parity_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy, dout, dout_vld, dout_par, busy;
  logic       din_rdy_m, dout_m, dout_vld_m, dout_par_m, busy_m;

  int checks;
  int errors;

  even_parity_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_par(dout_par), .busy(busy)
  );

  even_parity_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_m),
    .dout(dout_m), .dout_vld(dout_vld_m), .dout_par(dout_par_m), .busy(busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge. Inputs change and outputs are sampled 1 time
  // unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a full frame of 9 cycles. Bit i of exp holds the i-th emitted
  // bit, and bit 8 holds the parity bit. When this task returns, the run is
  // 1 time unit after the edge that ends the parity cycle.
  task automatic run_frame(input string tag, input bit m, input logic [8:0] exp);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s[%0d].dout", tag, i), m ? dout_m : dout, exp[i]);
      chk($sformatf("%s[%0d].vld", tag, i), m ? dout_vld_m : dout_vld, 1'b1);
      chk($sformatf("%s[%0d].par", tag, i), m ? dout_par_m : dout_par, (i == 8) ? 1'b1 : 1'b0);
      chk($sformatf("%s[%0d].busy", tag, i), m ? busy_m : busy, 1'b1);
      chk($sformatf("%s[%0d].rdy", tag, i), m ? din_rdy_m : din_rdy, (i == 8) ? 1'b1 : 1'b0);
      step();
    end
  endtask

  task automatic chk_idle(input string tag, input bit m);
    chk({tag, ".vld"}, m ? dout_vld_m : dout_vld, 1'b0);
    chk({tag, ".dout"}, m ? dout_m : dout, 1'b0);
    chk({tag, ".par"}, m ? dout_par_m : dout_par, 1'b0);
    chk({tag, ".busy"}, m ? busy_m : busy, 1'b0);
    chk({tag, ".rdy"}, m ? din_rdy_m : din_rdy, 1'b1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    din     = 8'h5A;
    din_vld = 1'b1;
    step();
    step();
    step();
    chk_idle("reset", 1'b0);
    chk_idle("reset_m", 1'b0);

    // Leave reset with din_vld low. A din_vld seen during reset must not
    // start a frame.
    rst     = 1'b1;
    din_vld = 1'b0;
    step();
    chk_idle("post_reset", 1'b0);

    // A5, LSB first: 1,0,1,0,0,1,0,1 then parity 0.
    din     = 8'hA5;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    din     = 8'h00;
    run_frame("a5", 1'b0, 9'h0A5);
    chk_idle("a5_idle", 1'b0);

    // 07, LSB first: 1,1,1,0,0,0,0,0 then parity 1.
    din     = 8'h07;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    run_frame("x07", 1'b0, 9'h107);
    chk_idle("x07_idle", 1'b0);

    // Back to back: FF, with 01 held valid. 01 is accepted in the parity cycle.
    din     = 8'hFF;
    din_vld = 1'b1;
    step();
    din     = 8'h01;
    run_frame("ff", 1'b0, 9'h0FF);
    din_vld = 1'b0;
    run_frame("x01", 1'b0, 9'h101);
    chk_idle("b2b_idle", 1'b0);

    // din changes in the middle of the frame while din_vld stays high.
    // The frame still sends 3C, and C3 is accepted in the parity cycle.
    din     = 8'h3C;
    din_vld = 1'b1;
    step();
    din     = 8'hC3;
    run_frame("x3c", 1'b0, 9'h03C);
    din_vld = 1'b0;
    din     = 8'h00;
    run_frame("xc3", 1'b0, 9'h0C3);
    chk_idle("hold_idle", 1'b0);

    // Reset is asserted at the edge after the third data bit of A5.
    din     = 8'hA5;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    chk("abort[0].dout", dout, 1'b1);
    step();
    chk("abort[1].dout", dout, 1'b0);
    step();
    chk("abort[2].dout", dout, 1'b1);
    chk("abort[2].vld", dout_vld, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_idle("abort_rst", 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort_tail[%0d].vld", i), dout_vld, 1'b0);
      chk($sformatf("abort_tail[%0d].par", i), dout_par, 1'b0);
      step();
    end

    // 80, MSB first: 1,0,0,0,0,0,0,0 then parity 1.
    din     = 8'h80;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    run_frame("msb80", 1'b1, 9'h101);
    chk_idle("msb_idle", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/even_parity_tx.md
EVEN_PARITY_TX -- requirements
Module: even_parity_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 0, serialization order: 0 = LSB first, 1 = MSB first.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din  input  DATA_W  parallel payload, sampled on accept.
REQ-006 SHALL have port din_vld  input  1  payload offered.
REQ-007 SHALL have port din_rdy  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port dout  output  1  serial bit stream, registered.
REQ-009 SHALL have port dout_vld  output  1  dout carries a frame bit this cycle, registered.
REQ-010 SHALL have port dout_par  output  1  current dout bit is the parity bit, registered.
REQ-011 SHALL have port busy  output  1  frame in progress; high whenever dout_vld is high.

Function
REQ-012 Accept SHALL occur on a rising clk edge where din_vld && din_rdy; din SHALL be captured into an internal shift register only on accept.
REQ-013 FSM states SHALL be IDLE, DATA and PARITY; any unencoded state SHALL recover to IDLE on the next edge.
REQ-014 IDLE: din_rdy=1; on accept go to DATA, else stay in IDLE.
REQ-015 DATA: din_rdy=0; emit exactly DATA_W bits, one per cycle; bit counter wraps from DATA_W-1 to PARITY.
REQ-016 PARITY: emit one bit equal to the XOR of all DATA_W captured bits, so the total ones count across data plus parity is even; dout_par=1 in this cycle only.
REQ-017 PARITY: din_rdy=1; on accept go directly to DATA, giving back-to-back frames with no gap cycle; without accept go to IDLE.
REQ-018 Latency: accept at edge N SHALL put the first data bit on dout with dout_vld=1 in the cycle after edge N.
REQ-019 A frame SHALL be exactly DATA_W+1 consecutive dout_vld cycles.
REQ-020 Order: MSB_FIRST=0 emits din[0] first; MSB_FIRST=1 emits din[DATA_W-1] first.
REQ-021 When dout_vld=0, dout and dout_par SHALL be 0.
REQ-022 Parity SHALL be computed from the captured copy; changes on din after accept SHALL NOT affect the frame.
REQ-023 din_vld while din_rdy=0 SHALL be ignored; the upstream holds din and din_vld.
REQ-024 busy SHALL be 1 in DATA and PARITY and 0 in IDLE.

Reset
REQ-025 While rst=0 at an edge: state IDLE, counter 0, shift register 0, dout=0, dout_vld=0, dout_par=0, busy=0.
REQ-026 din_rdy SHALL be 1 in the first cycle after reset deasserts.
REQ-027 Reset mid-frame SHALL abort the frame: no remaining data bits and no parity bit are emitted, and dout_vld=0 from the cycle after the reset edge.
REQ-028 A din_vld asserted while rst=0 SHALL NOT be accepted.

Verification
REQ-029 DATA_W=8, MSB_FIRST=0, din=8'hA5, single accept -> dout 1,0,1,0,0,1,0,1 then parity 0 with dout_par=1; 9 dout_vld cycles; then IDLE with din_rdy=1.
REQ-030 din=8'h07, LSB first -> dout 1,1,1,0,0,0,0,0 then parity 1.
REQ-031 Back-to-back: 8'hFF accepted, 8'h01 held valid -> second accept on the parity cycle; 18 contiguous dout_vld cycles; parities 0 then 1.
REQ-032 din_vld held high during DATA with din changed mid-frame -> din_rdy=0 throughout DATA; the frame uses the originally captured value; the new value is accepted in the PARITY cycle.
REQ-033 rst=0 at edge after third data bit of 8'hA5 -> next cycle dout_vld=0, dout=0, busy=0, din_rdy=1; no parity bit emitted.
REQ-034 MSB_FIRST=1, din=8'h80 -> dout 1,0,0,0,0,0,0,0 then parity 1.
